// File: rtl/aes256_seq_ctrl.sv
// AES-256 sequencing controller: register file for key/plaintext/result,
// launch/wait FSM around an external AES-256 core, timeout watchdog and
// sticky status flags with a level interrupt.
//
// state    | meaning
// ---------+-------------------------------------------------
// S_IDLE   | waiting for a START write
// S_LAUNCH | core_start asserted for exactly this cycle
// S_WAIT   | waiting for core_done, timeout counter running
module aes256_seq_ctrl #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         reg_wr_en,
  input  logic         reg_rd_en,
  input  logic [4:0]   reg_addr,
  input  logic [31:0]  reg_wdata,
  output logic [31:0]  reg_rdata,
  output logic         reg_rd_valid,
  output logic [255:0] core_key,
  output logic [127:0] core_din,
  output logic         core_start,
  input  logic         core_done,
  input  logic [127:0] core_dout,
  output logic         irq
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    key_q    [8];
  logic [31:0]    key_d    [8];
  logic [31:0]    pt_q     [4];
  logic [31:0]    pt_d     [4];
  logic [31:0]    result_q [4];
  logic [31:0]    result_d [4];
  logic           irq_en_q, irq_en_d;
  logic           done_q, done_d;
  logic           timeout_q, timeout_d;
  logic           overrun_q, overrun_d;
  logic           irq_q, irq_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           rd_valid_q;

  logic busy;
  logic ctrl_wr;
  logic start_req;
  logic clr_req;

  assign busy      = (state_q != S_IDLE);
  assign ctrl_wr   = reg_wr_en && (reg_addr == 5'd16);
  assign start_req = ctrl_wr && reg_wdata[0];
  assign clr_req   = ctrl_wr && reg_wdata[2];

  assign core_key     = {key_q[0], key_q[1], key_q[2], key_q[3],
                         key_q[4], key_q[5], key_q[6], key_q[7]};
  assign core_din     = {pt_q[0], pt_q[1], pt_q[2], pt_q[3]};
  assign core_start   = (state_q == S_LAUNCH);
  assign reg_rdata    = rdata_q;
  assign reg_rd_valid = rd_valid_q;
  assign irq          = irq_q;

  // Next-state logic for FSM, register writes and status flags.
  // Clears are applied first so a same-cycle set wins.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    pt_d      = pt_q;
    result_d  = result_q;
    irq_en_d  = irq_en_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    overrun_d = overrun_q;

    if (reg_wr_en && !busy) begin
      if (reg_addr < 5'd8) begin
        key_d[reg_addr[2:0]] = reg_wdata;
      end else if (reg_addr < 5'd12) begin
        pt_d[reg_addr[1:0]] = reg_wdata;
      end
    end

    if (ctrl_wr) begin
      irq_en_d = reg_wdata[1];
    end

    if (clr_req) begin
      done_d    = 1'b0;
      timeout_d = 1'b0;
      overrun_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          state_d   = S_LAUNCH;
          done_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (core_done) begin
          result_d[0] = core_dout[127:96];
          result_d[1] = core_dout[95:64];
          result_d[2] = core_dout[63:32];
          result_d[3] = core_dout[31:0];
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (busy && start_req) begin
      overrun_d = 1'b1;
    end

    irq_d = irq_en_d && (done_d || timeout_d);
  end

  // Read mux sampled from current register contents (pre-write on a collision).
  always_comb begin
    rdata_d = rdata_q;
    if (reg_rd_en) begin
      rdata_d = '0;
      if (reg_addr < 5'd8) begin
        rdata_d = key_q[reg_addr[2:0]];
      end else if (reg_addr < 5'd12) begin
        rdata_d = pt_q[reg_addr[1:0]];
      end else if (reg_addr < 5'd16) begin
        rdata_d = result_q[reg_addr[1:0]];
      end else if (reg_addr == 5'd16) begin
        rdata_d = {29'd0, 1'b0, irq_en_q, 1'b0};
      end else if (reg_addr == 5'd17) begin
        rdata_d = {28'd0, overrun_q, timeout_q, done_q, busy};
      end
    end
  end

  // State, register file and output registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      for (int i = 0; i < 8; i++) key_q[i] <= '0;
      for (int i = 0; i < 4; i++) pt_q[i] <= '0;
      for (int i = 0; i < 4; i++) result_q[i] <= '0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_q      <= key_d;
      pt_q       <= pt_d;
      result_q   <= result_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= reg_rd_en;
    end
  end

endmodule

// File: tb/tb_aes256_seq_ctrl.sv
// Directed testbench for aes256_seq_ctrl: encrypt, edge timing, timeout,
// overrun, reset mid-operation and unmapped access.
module tb_aes256_seq_ctrl;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         reg_wr_en = 1'b0;
  logic         reg_rd_en = 1'b0;
  logic [4:0]   reg_addr = '0;
  logic [31:0]  reg_wdata = '0;
  logic [31:0]  reg_rdata;
  logic         reg_rd_valid;
  logic [255:0] core_key;
  logic [127:0] core_din;
  logic         core_start;
  logic         core_done = 1'b0;
  logic [127:0] core_dout = '0;
  logic         irq;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int s0;

  logic [255:0] key_exp = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  logic [127:0] pt_exp  = 128'h00112233445566778899aabbccddeeff;
  logic [127:0] ct1     = 128'h8ea2b7ca516745bfeafc49904b496089;
  logic [127:0] ct2     = 128'hcafef00d_12345678_9abcdef0_0badc0de;
  logic [127:0] ct3     = 128'h55aa55aa_01020304_a5a5a5a5_feedface;

  aes256_seq_ctrl #(.TIMEOUT_CYC(64)) dut (
    .clock        (clock),
    .reset        (reset),
    .reg_wr_en    (reg_wr_en),
    .reg_rd_en    (reg_rd_en),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_rdata    (reg_rdata),
    .reg_rd_valid (reg_rd_valid),
    .core_key     (core_key),
    .core_din     (core_din),
    .core_start   (core_start),
    .core_done    (core_done),
    .core_dout    (core_dout),
    .irq          (irq)
  );

  always #5 clock = ~clock;

  // Count launch pulses seen by the core.
  always @(posedge clock) begin
    if (core_start) start_cnt <= start_cnt + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    reg_wr_en = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    tick();
    reg_wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    reg_rd_en = 1'b1;
    reg_addr  = a;
    tick();
    reg_rd_en = 1'b0;
    check({tag, "_vld"}, reg_rd_valid, 1'b1);
    check(tag, reg_rdata, exp);
  endtask

  initial begin
    // Reset state
    #12 reset = 1'b0;
    tick();
    check("rst_rdata", reg_rdata, 0);
    check("rst_valid", reg_rd_valid, 0);
    check("rst_key", core_key, 0);
    check("rst_din", core_din, 0);
    check("rst_start", core_start, 0);
    check("rst_irq", irq, 0);
    rd_chk("rst_status", 5'd17, 32'h0);

    // Basic encrypt
    for (int i = 0; i < 8; i++) wr(5'(i), key_exp[255-32*i -: 32]);
    wr(5'd8, 32'h11111111);
    wr(5'd9, pt_exp[95:64]);
    wr(5'd10, pt_exp[63:32]);
    wr(5'd11, pt_exp[31:0]);
    reg_wr_en = 1'b1;
    reg_rd_en = 1'b1;
    reg_addr  = 5'd8;
    reg_wdata = pt_exp[127:96];
    tick();
    reg_wr_en = 1'b0;
    reg_rd_en = 1'b0;
    check("rw_same_addr", reg_rdata, 32'h11111111);
    check("core_key", core_key, key_exp);
    check("core_din", core_din, pt_exp);
    wr(5'd16, 32'h2);
    rd_chk("ctrl_irqen", 5'd16, 32'h2);
    wr(5'd16, 32'h3);
    check("launch_start", core_start, 1);
    tick();
    check("wait_start", core_start, 0);
    rd_chk("enc_busy", 5'd17, 32'h1);
    repeat (11) tick();
    core_done = 1'b1;
    core_dout = ct1;
    tick();
    core_done = 1'b0;
    core_dout = '0;
    check("enc_irq", irq, 1);
    rd_chk("enc_status", 5'd17, 32'h2);
    for (int i = 0; i < 4; i++) rd_chk("enc_result", 5'(12 + i), ct1[127-32*i -: 32]);
    rd_chk("ctrl_start_rd0", 5'd16, 32'h2);

    // core_done on START write cycle and during LAUNCH is ignored;
    // core_done on the last WAIT cycle beats timeout
    reg_wr_en = 1'b1;
    reg_addr  = 5'd16;
    reg_wdata = 32'h3;
    core_done = 1'b1;
    core_dout = 128'hffff;
    tick();
    reg_wr_en = 1'b0;
    check("edge_launch", core_start, 1);
    tick();
    core_done = 1'b0;
    core_dout = '0;
    rd_chk("edge_ignored", 5'd17, 32'h1);
    repeat (62) tick();
    core_done = 1'b1;
    core_dout = ct2;
    tick();
    core_done = 1'b0;
    core_dout = '0;
    rd_chk("edge_last_done", 5'd17, 32'h2);
    rd_chk("edge_result", 5'd12, ct2[127:96]);

    // Timeout
    wr(5'd16, 32'h3);
    tick();
    rd_chk("to_result_busy", 5'd12, ct2[127:96]);
    repeat (62) tick();
    check("to_irq_pre", irq, 0);
    rd_chk("to_status_63", 5'd17, 32'h1);
    check("to_irq", irq, 1);
    rd_chk("to_status_64", 5'd17, 32'h4);
    rd_chk("to_result_hi", 5'd12, ct2[127:96]);
    rd_chk("to_result_lo", 5'd15, ct2[31:0]);

    // Overrun: START and KEY write while busy, then START with core_done
    s0 = start_cnt;
    wr(5'd16, 32'h3);
    tick();
    wr(5'd16, 32'h3);
    wr(5'd0, 32'hdeadbeef);
    reg_wr_en = 1'b1;
    reg_addr  = 5'd16;
    reg_wdata = 32'h3;
    core_done = 1'b1;
    core_dout = ct3;
    tick();
    reg_wr_en = 1'b0;
    core_done = 1'b0;
    core_dout = '0;
    rd_chk("ovr_status", 5'd17, 32'hA);
    rd_chk("ovr_key0", 5'd0, 32'h00010203);
    check("ovr_core_key", core_key, key_exp);
    rd_chk("ovr_result", 5'd12, ct3[127:96]);
    tick();
    check("ovr_one_start", start_cnt - s0, 1);
    wr(5'd16, 32'h6);
    rd_chk("clr_status", 5'd17, 32'h0);
    rd_chk("clr_ctrl", 5'd16, 32'h2);
    check("clr_irq", irq, 0);

    // Reset mid-WAIT
    wr(5'd16, 32'h3);
    tick();
    rd_chk("mid_key1", 5'd1, 32'h04050607);
    repeat (4) tick();
    #2 reset = 1'b1;
    #1;
    check("arst_rdata", reg_rdata, 0);
    check("arst_valid", reg_rd_valid, 0);
    check("arst_key", core_key, 0);
    check("arst_din", core_din, 0);
    check("arst_start", core_start, 0);
    check("arst_irq", irq, 0);
    #10 reset = 1'b0;
    tick();
    core_done = 1'b1;
    core_dout = ct1;
    tick();
    core_done = 1'b0;
    core_dout = '0;
    rd_chk("arst_status", 5'd17, 32'h0);
    rd_chk("arst_result", 5'd12, 32'h0);
    rd_chk("arst_ctrl", 5'd16, 32'h0);
    rd_chk("arst_key0", 5'd0, 32'h0);

    // Unmapped and read-only accesses
    wr(5'd20, 32'hffffffff);
    wr(5'd12, 32'h12345678);
    rd_chk("unmapped", 5'd20, 32'h0);
    tick();
    check("valid_one_cycle", reg_rd_valid, 0);
    rd_chk("ro_result", 5'd12, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes256_seq_ctrl.md
AES256_SEQ_CTRL -- requirements
Module: aes256_seq_ctrl

Interface
REQ-001 SHALL take parameter TIMEOUT_CYC, default 64: maximum cycles in WAIT before the core is declared hung.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port reg_wr_en, input, 1 bit: register write strobe, one cycle per write.
REQ-005 SHALL have port reg_rd_en, input, 1 bit: register read strobe.
REQ-006 SHALL have port reg_addr, input, 5 bits: word address.
REQ-007 SHALL have port reg_wdata, input, 32 bits: write data.
REQ-008 SHALL have port reg_rdata, output, 32 bits: registered read data.
REQ-009 SHALL have port reg_rd_valid, output, 1 bit: high the cycle after reg_rd_en.
REQ-010 SHALL have port core_key, output, 256 bits: key to the AES256 core.
REQ-011 SHALL have port core_din, output, 128 bits: plaintext to the core.
REQ-012 SHALL have port core_start, output, 1 bit: one-cycle launch pulse.
REQ-013 SHALL have port core_done, input, 1 bit: core completion pulse.
REQ-014 SHALL have port core_dout, input, 128 bits: core ciphertext, valid while core_done=1.
REQ-015 SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-016 SHALL implement this register map:
- 0-7: KEY, RW; addr 0 = key[255:224] ... addr 7 = key[31:0].
- 8-11: PT, RW; addr 8 = din[127:96].
- 12-15: RESULT, RO; addr 12 = dout[127:96].
- 16: CTRL; bit0 START (write-1 pulse, reads 0), bit1 IRQ_EN (RW), bit2 CLR (write-1 clears DONE/TIMEOUT/OVERRUN, reads 0).
- 17: STATUS, RO; bit0 BUSY, bit1 DONE, bit2 TIMEOUT, bit3 OVERRUN.
REQ-017 SHALL drive core_key and core_din continuously from the KEY and PT registers.
REQ-018 SHALL return 0 for reads of unmapped addresses (18-31) and ignore writes to them and to RO registers.
REQ-019 SHALL set reg_rdata/reg_rd_valid one cycle after reg_rd_en, with reg_rd_valid low otherwise; a simultaneous read and write to the same address returns the pre-write value.
REQ-020 SHALL implement FSM states IDLE, LAUNCH and WAIT; BUSY=1 in LAUNCH and WAIT.
REQ-021 SHALL accept START only in IDLE, on the write cycle N: enter LAUNCH at N+1 and clear DONE and TIMEOUT.
REQ-022 SHALL assert core_start for exactly the LAUNCH cycle (N+1), then enter WAIT at N+2 with the timeout counter at 0.
REQ-023 SHALL sample core_done only in WAIT; core_done in IDLE or LAUNCH is ignored.
REQ-024 SHALL, in WAIT with core_done=1: capture core_dout into RESULT, set DONE, and return to IDLE next cycle.
REQ-025 SHALL, in WAIT, increment the counter each cycle without core_done; when TIMEOUT_CYC cycles pass without core_done it sets TIMEOUT, returns to IDLE and leaves RESULT unchanged.
REQ-026 SHALL give core_done priority over timeout when both occur on the last WAIT cycle.
REQ-027 SHALL, while BUSY: ignore KEY/PT writes; treat START as ignored and set OVERRUN (sticky); still apply IRQ_EN and CLR writes.
REQ-028 SHALL, when START and core_done coincide in WAIT: capture the result, ignore START and set OVERRUN.
REQ-029 SHALL let CLR and a same-cycle DONE/TIMEOUT set resolve to set.
REQ-030 SHALL drive irq = IRQ_EN & (DONE | TIMEOUT), registered.
REQ-031 SHALL keep RESULT readable while BUSY, returning the previous result.

Reset
REQ-032 SHALL, on reset assertion, asynchronously force the FSM to IDLE and clear KEY, PT, RESULT, CTRL, STATUS and the counter; outputs go to reg_rdata=0, reg_rd_valid=0, core_start=0, irq=0, core_key=0, core_din=0.
REQ-033 SHALL abort an operation if reset is asserted mid-operation; a core_done arriving after reset release (in IDLE) is ignored.

Verification
REQ-034 SHALL be verified with a basic encrypt: key = FIPS-197 C.3 key 000102...1f, PT = 00112233445566778899aabbccddeeff, START, core model returns 8ea2b7ca516745bfeafc49904b496089 after 14 cycles -> RESULT matches, STATUS=0x2, irq=1 with IRQ_EN=1.
REQ-035 SHALL be verified with a timeout: core never asserts done, TIMEOUT_CYC=64 -> STATUS=0x4 exactly 64 cycles after entering WAIT, RESULT unchanged, BUSY=0.
REQ-036 SHALL be verified with an overrun: START plus a KEY write to addr 0 of 0xdeadbeef during WAIT -> OVERRUN=1, KEY addr 0 unchanged, a single core_start pulse; then CLR -> STATUS=0x0.
REQ-037 SHALL be verified with edge timing: core_done on the cycle START is written and during LAUNCH -> ignored; core_done on the final timeout cycle -> DONE=1, TIMEOUT=0.
REQ-038 SHALL be verified with reset mid-WAIT: reset asserted at WAIT cycle 5 -> all registers 0 immediately; a later core_done leaves DONE=0.
REQ-039 SHALL be verified with a read of addr 20 -> 0x00000000, and with reg_rd_valid high for exactly one cycle.
